alu_issue_ctrl: RTL and testbench

- Front-end sequencer for the 8-bit ALU datapath.
- Accepts one operation per request over a valid/ready handshake.
- Computes single-cycle ops (add, sub, mul, compare) internally.
- Drives the multi-cycle restoring divider through its start/busy/ready interface, then returns a registered result and flags downstream over a valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU front-end sequencer: single-cycle ops plus divider issue/wait.
// Optional signed SDIV/SMOD support is built when ALU_SIGNED_DIV_EN is defined.
module alu_issue_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [15:0] div_b,
  input  logic        div_busy,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  input  logic [15:0] div_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic [3:0]  rsp_flags
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, EXEC, DIV_ISSUE, DIV_WAIT, RESP} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [7:0]     a_q, b_q;
  logic [CW-1:0]  wait_cnt;

  logic [8:0]     sum9;
  logic [7:0]     diff;
  logic [15:0]    prod;
  logic [7:0]     exec_res;
  logic           exec_err, exec_dz, exec_carry;
  logic [7:0]     issue_a, issue_b;
  logic [7:0]     div_raw, div_res;
  logic           req_is_div;
  logic           unused_div_hi;

  assign unused_div_hi = ^{div_q[31:8], div_r[15:8]};

`ifdef ALU_SIGNED_DIV_EN
  assign req_is_div = req_op[2];
`else
  assign req_is_div = (req_op[2:1] == 2'b10);
`endif

  always_comb begin
    issue_a = req_a;
    issue_b = req_b;
`ifdef ALU_SIGNED_DIV_EN
    // Signed ops hand the divider magnitudes; signs are reapplied on return.
    if (req_op[2:1] == 2'b11) begin
      if (req_a[7]) issue_a = -req_a;
      if (req_b[7]) issue_b = -req_b;
    end
`endif
  end

  assign sum9 = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;
  assign prod = {8'b0, a_q} * {8'b0, b_q};

  always_comb begin
    exec_res   = 8'h00;
    exec_err   = 1'b0;
    exec_dz    = 1'b0;
    exec_carry = 1'b0;
    case (op_q)
      3'b000: begin exec_res = sum9[7:0]; exec_carry = sum9[8]; end
      3'b001: begin exec_res = diff;      exec_carry = (a_q >= b_q); end
      3'b010: begin exec_res = prod[7:0]; exec_carry = |prod[15:8]; end
      3'b011: exec_res = (diff == 8'h00) ? 8'h00 : (diff[7] ? 8'h01 : 8'h02);
      // Divide ops only reach EXEC with a zero divisor.
      3'b100: begin exec_dz = 1'b1; exec_res = 8'hFF; end
      3'b101: begin exec_dz = 1'b1; exec_res = a_q; end
`ifdef ALU_SIGNED_DIV_EN
      3'b110: begin exec_dz = 1'b1; exec_res = 8'hFF; end
      3'b111: begin exec_dz = 1'b1; exec_res = a_q; end
`endif
      default: exec_err = 1'b1;
    endcase
  end

  always_comb begin
    div_raw = op_q[0] ? div_r[7:0] : div_q[7:0];
    div_res = div_raw;
`ifdef ALU_SIGNED_DIV_EN
    if (op_q[1] && (op_q[0] ? a_q[7] : (a_q[7] ^ b_q[7])))
      div_res = -div_raw;
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      op_q       <= 3'b000;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      wait_cnt   <= '0;
      div_start  <= 1'b0;
      div_a      <= 32'h0;
      div_b      <= 16'h0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_flags  <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            if (req_is_div && (req_b != 8'h00)) begin
              state     <= DIV_ISSUE;
              div_start <= 1'b1;
              div_a     <= {24'b0, issue_a};
              div_b     <= {8'b0, issue_b};
            end else begin
              state <= EXEC;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        EXEC: begin
          rsp_result <= exec_res;
          rsp_flags  <= {exec_err, exec_dz, exec_carry, !exec_err && (exec_res == 8'h00)};
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        DIV_ISSUE: begin
          div_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= DIV_WAIT;
        end
        DIV_WAIT: begin
          // Count zero is the cycle the divider clears ready, so ready is not trusted there.
          if ((wait_cnt != '0) && div_ready && !div_busy) begin
            rsp_result <= div_res;
            rsp_flags  <= {3'b000, div_res == 8'h00};
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt == CW'(DIV_TIMEOUT - 1)) begin
            rsp_result <= 8'h00;
            rsp_flags  <= 4'b1000;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_start_only_in_issue: assert property (@(posedge clk) disable iff (!clrn)
    div_start |-> (state == DIV_ISSUE));
  a_ready_only_in_idle: assert property (@(posedge clk) disable iff (!clrn)
    req_ready |-> (state == IDLE));
  a_divider_fits_timeout: assert property (@(posedge clk) disable iff (!clrn)
    DIV_CYCLES < DIV_TIMEOUT);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural divider.
module tb_alu_issue_ctrl;

  localparam int DIV_TIMEOUT = 40;
  localparam int DIV_CYCLES  = 32;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a, req_b;
  logic        div_start;
  logic [31:0] div_a;
  logic [15:0] div_b;
  logic        div_busy = 1'b0, div_ready = 1'b0;
  logic [31:0] div_q = 32'h0;
  logic [15:0] div_r = 16'h0;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_q[$];

  int          dcnt = 0;
  int          start_count = 0;
  bit          div_hang = 1'b0;
  logic [31:0] last_div_a = 32'h0;
  logic [15:0] last_div_b = 16'h0;

  alu_issue_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_ready(div_ready), .div_q(div_q), .div_r(div_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Divider model: restarts on every start pulse, reports after DIV_CYCLES, ready held until next start.
  always @(posedge clk) begin
    if (div_start) begin
      start_count <= start_count + 1;
      last_div_a  <= div_a;
      last_div_b  <= div_b;
      div_busy    <= 1'b1;
      div_ready   <= 1'b0;
      dcnt        <= DIV_CYCLES;
      if (div_b != 16'h0) begin
        div_q <= div_a / {16'h0, div_b};
        div_r <= 16'(div_a % {16'h0, div_b});
      end
    end else if (div_busy) begin
      if (dcnt > 1) dcnt <= dcnt - 1;
      else if (!div_hang) begin
        div_busy  <= 1'b0;
        div_ready <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (clrn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("result", rsp_result, e[11:4]);
        check("flags", rsp_flags, e[3:0]);
      end
    end
  end

  task automatic rst_checks(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_div_start"}, div_start, 0);
    check({tag, "_div_a"}, div_a, 0);
    check({tag, "_div_b"}, div_b, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_flags"}, rsp_flags, 0);
  endtask

  // Called at posedge+1. lat counts clock edges from the accept edge to rsp_valid being seen.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef,
                      input int lat_lo, input int lat_hi, input int nstart, input int hold);
    int lat, s0, wt;
    logic [7:0] hr;
    logic [3:0] hf;
    s0 = start_count;
    exp_q.push_back({er, ef});
    rsp_ready = (hold == 0);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    wt = 0;
    while (!req_ready && wt < 20) begin @(posedge clk); #1; wt++; end
    check("accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check("lat_min", lat >= lat_lo, 1);
    check("lat_max", lat <= lat_hi, 1);
    if (hold > 0) begin
      hr = rsp_result;
      hf = rsp_flags;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", rsp_valid, 1);
        check("hold_result", rsp_result, hr);
        check("hold_flags", rsp_flags, hf);
        check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    wt = 0;
    while (rsp_valid && wt < 5) begin @(posedge clk); #1; wt++; end
    check("rsp_drop", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
    check("sb_empty", exp_q.size(), 0);
    check("start_pulses", start_count - s0, nstart);
  endtask

  initial begin
    clrn = 1'b0; req_valid = 1'b0; req_op = 3'b0; req_a = 8'h0; req_b = 8'h0; rsp_ready = 1'b1;
    #3 rst_checks("reset");
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    check("ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1);

    // Single-cycle ops: response one edge after EXEC, i.e. the second cycle after accept.
    send(3'b000, 8'hF0, 8'h20, 8'h10, 4'b0010, 1, 1, 0, 0);
    send(3'b001, 8'h05, 8'h09, 8'hFC, 4'b0000, 1, 1, 0, 0);
    send(3'b001, 8'h09, 8'h05, 8'h04, 4'b0010, 1, 1, 0, 0);
    send(3'b010, 8'h10, 8'h10, 8'h00, 4'b0011, 1, 1, 0, 0);
    send(3'b010, 8'h03, 8'h05, 8'h0F, 4'b0000, 1, 1, 0, 0);
    send(3'b011, 8'h05, 8'h09, 8'h01, 4'b0000, 1, 1, 0, 0);
    send(3'b011, 8'h09, 8'h09, 8'h00, 4'b0001, 1, 1, 0, 0);
    send(3'b011, 8'h09, 8'h05, 8'h02, 4'b0000, 1, 1, 0, 0);

    send(3'b100, 8'd100, 8'd7, 8'd14, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);
    check("div_a", last_div_a, 32'd100);
    check("div_b", last_div_b, 16'd7);
    send(3'b101, 8'd100, 8'd7, 8'd2, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);
    send(3'b101, 8'd21, 8'd7, 8'd0, 4'b0001, DIV_CYCLES, DIV_TIMEOUT, 1, 0);

    send(3'b100, 8'h33, 8'h00, 8'hFF, 4'b0100, 1, 1, 0, 0);
    send(3'b101, 8'h33, 8'h00, 8'h33, 4'b0100, 1, 1, 0, 0);

`ifdef ALU_SIGNED_DIV_EN
    send(3'b110, 8'h9C, 8'd7, 8'hF2, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);
    check("sdiv_div_a", last_div_a, 32'd100);
    send(3'b111, 8'h9C, 8'd7, 8'hFE, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);
    send(3'b110, 8'd100, 8'hF9, 8'hF2, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);
    send(3'b110, 8'h9C, 8'h00, 8'hFF, 4'b0100, 1, 1, 0, 0);
`else
    send(3'b110, 8'h9C, 8'd7, 8'h00, 4'b1000, 1, 1, 0, 0);
    send(3'b111, 8'h9C, 8'd7, 8'h00, 4'b1000, 1, 1, 0, 0);
`endif

    // Divider that never answers.
    div_hang = 1'b1;
    send(3'b100, 8'd50, 8'd5, 8'h00, 4'b1000, DIV_TIMEOUT, DIV_TIMEOUT + 3, 1, 0);
    div_hang = 1'b0;
    send(3'b100, 8'd50, 8'd5, 8'd10, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);

    // Back-pressure: response held for 10 cycles.
    send(3'b000, 8'h01, 8'h02, 8'h03, 4'b0000, 1, 1, 0, 10);

    // Reset while waiting on the divider: no response, then a clean op.
    rsp_ready = 1'b1;
    req_op = 3'b100; req_a = 8'd200; req_b = 8'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("div_busy_mid", div_busy, 1);
    clrn = 1'b0;
    #1 rst_checks("midreset");
    @(posedge clk); #1;
    rst_checks("midreset_hold");
    clrn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midreset", req_ready, 1);
    check("no_rsp_after_abort", rsp_valid, 0);
    send(3'b100, 8'd200, 8'd3, 8'd66, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);
    send(3'b101, 8'd200, 8'd3, 8'd2, 4'b0000, DIV_CYCLES, DIV_TIMEOUT, 1, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
